// File: rtl/tiny_pkg.sv
// Shared definitions for the program loader and the control unit:
// loader state codes and the MI/RI strobe encoding.
package tiny_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNT     = 3'd1;
  localparam logic [2:0] ST_WAIT_DATA = 3'd2;
  localparam logic [2:0] ST_SET_MAR   = 3'd3;
  localparam logic [2:0] ST_WRITE     = 3'd4;
  localparam logic [2:0] ST_CHECK     = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  typedef enum logic [2:0] {
    LS_IDLE      = ST_IDLE,
    LS_COUNT     = ST_COUNT,
    LS_WAIT_DATA = ST_WAIT_DATA,
    LS_SET_MAR   = ST_SET_MAR,
    LS_WRITE     = ST_WRITE,
    LS_CHECK     = ST_CHECK,
    LS_DONE      = ST_DONE
  } loader_state_e;

  // Strobe pair packed as {MI, RI}; the two are mutually exclusive.
  localparam logic [1:0] STROBE_NONE = 2'b00;
  localparam logic [1:0] STROBE_MI   = 2'b10;
  localparam logic [1:0] STROBE_RI   = 2'b01;

  function automatic logic accepts_word(input logic [2:0] st);
    return (st == ST_IDLE) || (st == ST_COUNT) ||
           (st == ST_WAIT_DATA) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams a {addr, count, data...} frame into memory through MI/RI strobes.
// Define PROG_LOADER_CHECKSUM_EN to add a trailing checksum word and the err flag.
module prog_loader
  import tiny_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             MI,
  output logic             RI,
  output logic [WIDTH-1:0] write,
  output logic             busy,
  output logic             done,
  output logic             err,
  output loader_state_e    dbg_state
);

  logic [2:0]       state;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] data;
  logic [1:0]       strobe;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] sum;
  logic             err_q;
`endif

  // Handshake: a word transfers on a posedge where s_valid && s_ready.
  // s_ready depends only on state, so upstream may hold s_valid indefinitely.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      addr  <= '0;
      count <= '0;
      data  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum   <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            addr  <= s_data;
            state <= ST_COUNT;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum   <= '0;
            err_q <= 1'b0;
`endif
          end
        end
        ST_COUNT: begin
          if (s_valid) begin
            count <= s_data;
            state <= (s_data == '0) ? ST_DONE : ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (s_valid) begin
            data  <= s_data;
            state <= ST_SET_MAR;
          end
        end
        ST_SET_MAR: begin
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          addr  <= addr + WIDTH'(1);
          count <= count - WIDTH'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          sum   <= sum + data;
          state <= (count == WIDTH'(1)) ? ST_CHECK : ST_WAIT_DATA;
`else
          state <= (count == WIDTH'(1)) ? ST_DONE : ST_WAIT_DATA;
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (s_valid) begin
            err_q <= (s_data != sum);
            state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    strobe = STROBE_NONE;
    write  = '0;
    case (state)
      ST_SET_MAR: begin
        strobe = STROBE_MI;
        write  = addr;
      end
      ST_WRITE: begin
        strobe = STROBE_RI;
        write  = data;
      end
      default: begin
        strobe = STROBE_NONE;
        write  = '0;
      end
    endcase
  end

  assign {MI, RI}  = strobe;
  assign s_ready   = accepts_word(state);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = loader_state_e'(state);

`ifdef PROG_LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (WIDTH=8) with a strobe/done scoreboard and a
// simple MAR/RAM model driven by the MI/RI strobes.
module tb_prog_loader;
  import tiny_pkg::*;

  localparam int W  = 8;
  localparam int EW = W + 3;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          mi, ri, busy, done, err;
  logic [W-1:0]  write;
  loader_state_e dbg_state;

  logic [W-1:0]  mem [256] = '{default: 8'h00};
  logic [W-1:0]  mar = '0;

  logic [EW-1:0] exp_q [$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [W-1:0]  dv [8];

  prog_loader #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .MI(mi), .RI(ri), .write(write), .busy(busy),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: MI loads MAR, RI stores to ram[MAR]
  always @(posedge clk) begin
    if (mi) mar <= write;
    if (ri) mem[mar] <= write;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every strobe or done cycle pops one expected event
  always @(negedge clk) begin
    logic [EW-1:0] obs;
    logic [EW-1:0] e;
    if (!reset) begin
      obs = {mi, ri, done, write};
      if (mi || ri || done) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got 0x%0h expected none at %0t", obs, $time);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_err++;
            $display("FAIL event: got 0x%0h expected 0x%0h at %0t", obs, e, $time);
          end
        end
      end else begin
        n_vec++;
        if (write !== '0) begin
          n_err++;
          $display("FAIL idle_write: got 0x%0h expected 0x0 at %0t", write, $time);
        end
      end
    end
  end

  // driver: called at a negedge; returns at the negedge after the handshake
  task automatic send_word(input logic [W-1:0] w);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("send_timeout", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic run_frame(input logic [W-1:0] a, input int n, input logic [W-1:0] cks,
                           input bit lat, input bit toggle);
    logic [W-1:0] s = '0;
    int guard;
    int idx;
    bit ph;
    bit hs;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({3'b100, a + W'(i)});
      exp_q.push_back({3'b010, dv[i]});
      s = s + dv[i];
    end
    exp_q.push_back({3'b001, {W{1'b0}}});

    send_word(a);
    check("err_clear_hdr", 32'(err), 32'd0);
    send_word(W'(n));
    if (n == 0) begin
      check("n0_done", 32'(done), 32'd1);
      check("n0_busy", 32'(busy), 32'd1);
    end else if (toggle) begin
      idx = 0; guard = 0; ph = 1'b1;
      while (idx < n && guard < 200) begin
        s_valid = ph;
        s_data  = dv[idx];
        hs = ph && s_ready;
        @(negedge clk);
        if (hs) idx++;
        ph = !ph;
        guard++;
      end
      s_valid = 1'b0;
      s_data  = '0;
      check("toggle_words", 32'(idx), 32'(n));
    end else begin
      for (int i = 0; i < n; i++) begin
        send_word(dv[i]);
        if (lat) begin
          check("lat_mi", {mi, ri, write}, {2'b10, a + W'(i)});
          @(negedge clk);
          check("lat_ri", {mi, ri, write}, {2'b01, dv[i]});
          @(negedge clk);
          if (i < n - 1 || CKS) check("lat_ready", 32'(s_ready), 32'd1);
        end
      end
    end
    if (n > 0 && CKS) send_word(cks);

    guard = 0;
    while (!done && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("err_frame", 32'(err), (CKS && n > 0) ? 32'(cks != s) : 32'd0);
    @(negedge clk);
    check("busy_fall", {busy, done}, 2'b00);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < n; i++) check("mem", 32'(mem[a + W'(i)]), 32'(dv[i]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_state", {s_ready, mi, ri, busy, done, err}, 6'b100000);
    check("rst_write", 32'(write), 32'd0);
    check("rst_dbg", 32'(dbg_state), 32'(ST_IDLE));

    // basic frame with cycle-exact latency checks
    dv = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(8'd100, 3, 8'h66, 1'b1, 1'b0);

    // address wrap
    dv = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(8'hFE, 3, 8'h06, 1'b0, 1'b0);

    // empty frame
    run_frame(8'd50, 0, 8'h00, 1'b0, 1'b0);

    // s_valid toggling every cycle during data
    dv = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(8'd120, 3, 8'h66, 1'b0, 1'b1);

    // reset one cycle after the second data RI of a 4-word frame
    exp_q.push_back({3'b100, 8'd20});
    exp_q.push_back({3'b010, 8'hA1});
    exp_q.push_back({3'b100, 8'd21});
    exp_q.push_back({3'b010, 8'hA2});
    send_word(8'd20);
    send_word(8'd4);
    send_word(8'hA1);
    send_word(8'hA2);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_state", {s_ready, mi, ri, busy, done, err}, 6'b100000);
    check("mid_rst_write", 32'(write), 32'd0);
    check("mid_rst_dbg", 32'(dbg_state), 32'(ST_IDLE));
    repeat (4) @(negedge clk);
    check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    check("mid_rst_mem20", 32'(mem[20]), 32'hA1);
    check("mid_rst_mem21", 32'(mem[21]), 32'hA2);
    check("mid_rst_mem22", 32'(mem[22]), 32'h00);
    check("mid_rst_mem23", 32'(mem[23]), 32'h00);

    // loader recovers after reset
    dv = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(8'd200, 1, 8'h5A, 1'b0, 1'b0);

    // checksum good, bad, then good again (err clears at the header)
    dv = '{8'd5, 8'd7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(8'd10, 2, 8'd12, 1'b0, 1'b0);
    run_frame(8'd10, 2, 8'd13, 1'b0, 1'b0);
    check("err_held", 32'(err), 32'(CKS));
    dv = '{8'd9, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(8'd30, 1, 8'd9, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: WIDTH, default 16, data and address word width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s_valid  input  1  upstream word valid.
REQ-005 s_ready  output  1  loader accepts s_data this cycle when s_valid && s_ready.
REQ-006 s_data  input  WIDTH  upstream word.
REQ-007 MI  output  1  memory-address-latch strobe; memory loads MAR from write on this clk.
REQ-008 RI  output  1  memory-write strobe; memory stores write to ram[MAR] on this clk.
REQ-009 write  output  WIDTH  memory write bus, valid when MI or RI is high.
REQ-010 busy  output  1  high while a frame is in progress; the system uses it to hold the CPU.
REQ-011 done  output  1  one-cycle pulse at frame end.
REQ-012 err  output  1  checksum mismatch flag for the last frame.

Function
REQ-013 Frame format: word0 = start address, word1 = count N, then N data words.
REQ-014 FSM states: IDLE, COUNT, WAIT_DATA, SET_MAR, WRITE, CHECK (macro only), DONE.
REQ-015 s_ready is high only in IDLE, COUNT, WAIT_DATA and CHECK; it is low in all other states.
REQ-016 IDLE: on handshake, latch addr, clear err, set busy, go to COUNT.
REQ-017 COUNT: on handshake, latch N; N==0 -> DONE, else -> WAIT_DATA.
REQ-018 WAIT_DATA: on handshake, latch data, go to SET_MAR.
REQ-019 SET_MAR: MI=1, RI=0, write=addr for exactly one cycle, then go to WRITE.
REQ-020 WRITE: RI=1, MI=0, write=data for exactly one cycle; addr<=addr+1 mod 2^WIDTH; decrement remaining count; if remaining becomes 0 go to CHECK (macro) or DONE, else go to WAIT_DATA.
REQ-021 Latency: data accepted in cycle n gives MI in n+1, RI in n+2, and s_ready again in n+3. Throughput is 1 word per 3 cycles at best.
REQ-022 MI and RI are never high in the same cycle. Both are low outside SET_MAR and WRITE, and write=0 outside those states.
REQ-023 Address wraps from 2^WIDTH-1 to 0 silently.
REQ-024 DONE: done=1 and busy=1 for one cycle, then go to IDLE with busy=0.
REQ-025 s_valid low in any accepting state causes the FSM to hold with no strobes.
REQ-026 The loader cannot be aborted except by reset.

Reset
REQ-027 When reset is sampled high, the FSM goes to IDLE and s_ready=1; MI, RI, busy, done and err go to 0; write=0; internal addr, count, data and checksum go to 0.
REQ-028 Reset mid-frame abandons the frame. Words already written stay in memory, and no done pulse is issued.

Configuration
REQ-029 Macro PROG_LOADER_CHECKSUM_EN: when defined, the loader keeps sum = sum of the N data words mod 2^WIDTH. After the last WRITE, CHECK accepts one extra word; on mismatch err=1, held until the next frame start or reset. DONE follows either way.
REQ-030 Without PROG_LOADER_CHECKSUM_EN: no CHECK state and no trailing word, and err is constant 0.

Structure
REQ-031 Package tiny_pkg holds the loader state enum typedef and the MI/RI strobe encoding constants shared with the control unit.
REQ-032 No sub-module: the checksum is a single adder/register inside prog_loader.

Verification
REQ-033 WIDTH=8, frame {100,3,0x11,0x22,0x33}: MI with write=100,101,102, each followed next cycle by RI with 0x11,0x22,0x33; memory[100..102] correct; done pulses once.
REQ-034 Frame {0xFE,3,1,2,3}: writes land at 0xFE, 0xFF, 0x00 (address wrap).
REQ-035 Frame {50,0}: no MI/RI strobes; done pulses in the cycle after the count handshake; busy falls in the cycle after that.
REQ-036 Reset asserted one cycle after the 2nd data RI of a 4-word frame: outputs match the reset values on the next cycle; only 2 words are written; no done pulse.
REQ-037 s_valid toggled 1-0-1 every cycle during data: no strobe in any stalled cycle; final memory contents identical to REQ-033.
REQ-038 With PROG_LOADER_CHECKSUM_EN, frame {10,2,5,7,12}: err=0. A second frame with checksum 13: err=1. A third correct frame clears err at its header.
